// File: rtl/uart_pkg.sv
// Shared constants for the wishbone UART transmitter and receiver: register map,
// status bit layout, identification word and FSM state encodings.
package uart_pkg;

    localparam logic [1:0] REG_DIVIDER = 2'd0;
    localparam logic [1:0] REG_RXDATA  = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_SANITY  = 2'd3;

    localparam int STAT_VALID     = 0;
    localparam int STAT_OVERRUN   = 1;
    localparam int STAT_FRAME_ERR = 2;
    localparam int STAT_OCC_LSB   = 4;

    localparam logic [31:0] SANITY_VALUE  = 32'h5EC0B0B0;
    localparam logic [31:0] DIVIDER_RESET = 32'd1;
    localparam int          UART_DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // Both ends derive the bit time the same way so one divider value serves both.
    function automatic logic [31:0] bit_period(input logic [31:0] div);
        return div + 32'd2;
    endfunction

endpackage

// File: rtl/wb_uart_rx_if.sv
// Wishbone classic slave bus bundle for the UART receiver register window.
interface wb_uart_rx_if #(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8
) ();

    logic [WB_ADDR_WIDTH-1:0] wb_addr_i;
    logic [WB_DATA_WIDTH-1:0] wb_data_i;
    logic [WB_SEL_WIDTH-1:0]  wb_sel_i;
    logic                     wb_we_i;
    logic                     wb_cyc_i;
    logic                     wb_stb_i;
    logic                     wb_ack_o;
    logic [WB_DATA_WIDTH-1:0] wb_data_o;

    modport slave (
        input  wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_ack_o, wb_data_o
    );

    modport master (
        output wb_addr_i, wb_data_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_ack_o, wb_data_o
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes; a push into a full FIFO succeeds
// only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             wr_ok, rd_ok;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign wr_ok = push & (~full | pop);
    assign rd_ok = pop & ~empty;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone-slave 8N1 UART receiver with DIVIDER/RXDATA/STATUS/SANITY registers.
// Define UART_RX_FIFO_EN to buffer bytes in uart_rx_fifo instead of one holding register.
module wb_uart_rx
    import uart_pkg::*;
#(
    parameter int WB_DATA_WIDTH = 32,
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_SEL_WIDTH  = WB_DATA_WIDTH / 8,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        uart_rx_i,
    wb_uart_rx_if.slave wb,
    output logic        rx_irq_o
);

    logic                     rx_s1, rx_s2, rx_prev;
    logic                     ack, access, rd_ack, wr_ack;
    logic [1:0]               reg_idx;
    logic [31:0]              divider, div_work, cnt, period;
    logic [2:0]               bit_idx;
    logic [7:0]               shift, rx_byte;
    logic [3:0]               occ;
    logic                     load, cnt_clr, shift_en, push, frame_set, tick_half, tick_full;
    logic                     valid, pop, overrun_set, overrun, frame_err;
    logic [WB_DATA_WIDTH-1:0] rdata;
    rx_state_t                state, state_nxt;
    logic                     unused_ok;

    assign unused_ok = ^{wb.wb_sel_i, wb.wb_addr_i[WB_ADDR_WIDTH-1:4], wb.wb_addr_i[1:0],
                         32'(FIFO_DEPTH), 32'(WB_SEL_WIDTH)};

    // Synchroniser plus one more sample so IDLE can demand a genuine falling edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) {rx_s1, rx_s2, rx_prev} <= 3'b111;
        else begin
            rx_s1   <= uart_rx_i;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign access  = wb.wb_cyc_i & wb.wb_stb_i;
    assign reg_idx = wb.wb_addr_i[3:2];
    assign rd_ack  = ack & ~wb.wb_we_i;
    assign wr_ack  = ack & wb.wb_we_i;
    assign wb.wb_ack_o = ack;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ack     <= 1'b0;
            divider <= DIVIDER_RESET;
        end else begin
            ack <= access & ~ack;
            if (wr_ack && reg_idx == REG_DIVIDER) divider <= wb.wb_data_i;
        end
    end

    assign period    = bit_period(div_work);
    assign tick_half = (cnt == (period >> 1) - 32'd1);
    assign tick_full = (cnt == period - 32'd1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state)
            IDLE:  if (!rx_s2 && rx_prev) begin
                       load      = 1'b1;
                       state_nxt = START;
                   end
            START: if (tick_half) begin
                       cnt_clr   = 1'b1;
                       state_nxt = rx_s2 ? IDLE : DATA;
                   end
            DATA:  if (tick_full) begin
                       cnt_clr  = 1'b1;
                       shift_en = 1'b1;
                       if (bit_idx == 3'(UART_DATA_BITS - 1)) state_nxt = STOP;
                   end
            STOP:  if (tick_full) begin
                       push      = rx_s2;
                       frame_set = ~rx_s2;
                       state_nxt = IDLE;
                   end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            bit_idx  <= '0;
            div_work <= DIVIDER_RESET;
        end else begin
            if (load || cnt_clr)    cnt <= '0;
            else if (state != IDLE) cnt <= cnt + 32'd1;
            if (load)               bit_idx <= '0;
            else if (shift_en)      bit_idx <= bit_idx + 3'd1;
            if (load)               div_work <= divider;
        end
    end

    always_ff @(posedge clk_i) begin
        if (shift_en) shift <= {rx_s2, shift[7:1]};
    end

    assign pop = rd_ack && (reg_idx == REG_RXDATA) && valid;

`ifdef UART_RX_FIFO_EN
    logic                        fifo_full, fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (shift),
        .rdata (rx_byte),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign valid       = ~fifo_empty;
    assign overrun_set = push & fifo_full & ~pop;
    assign occ         = 4'(fifo_count);
`else
    logic       hold_valid;
    logic [7:0] hold_data;
    logic       hold_wr;

    assign hold_wr = push & (~hold_valid | pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        hold_valid <= 1'b0;
        else if (hold_wr) hold_valid <= 1'b1;
        else if (pop)     hold_valid <= 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (hold_wr) hold_data <= shift;
    end

    assign valid       = hold_valid;
    assign rx_byte     = hold_data;
    assign overrun_set = push & hold_valid & ~pop;
    assign occ         = 4'd0;
`endif

    // Sticky error flags; a new error in the same cycle as its clear wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            rx_irq_o  <= 1'b0;
        end else begin
            rx_irq_o <= valid;
            if (overrun_set) overrun <= 1'b1;
            else if (wr_ack && reg_idx == REG_STATUS && wb.wb_data_i[STAT_OVERRUN]) overrun <= 1'b0;
            if (frame_set) frame_err <= 1'b1;
            else if (wr_ack && reg_idx == REG_STATUS && wb.wb_data_i[STAT_FRAME_ERR]) frame_err <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_DIVIDER: rdata = divider;
            REG_RXDATA:  rdata = valid ? {24'b0, rx_byte} : '0;
            REG_STATUS: begin
                rdata[STAT_OCC_LSB+3:STAT_OCC_LSB] = occ;
                rdata[STAT_FRAME_ERR]              = frame_err;
                rdata[STAT_OVERRUN]                = overrun;
                rdata[STAT_VALID]                  = valid;
            end
            default:     rdata = SANITY_VALUE;
        endcase
    end

    assign wb.wb_data_o = rd_ack ? rdata : '0;

endmodule

// File: doc/wb_uart_rx.md
Name: wb_uart_rx

Overview:
Wishbone-slave UART receiver, the receive-side counterpart of the existing wishbone UART transmitter; shares its divider semantics so one divider value serves both ends. Deserialises 8N1 frames from uart_rx_i into a holding register, or a small FIFO when the optional feature is enabled. Firmware reads bytes and error flags through a 4-word register window and can use rx_irq_o instead of polling.

Parameters:
WB_DATA_WIDTH, 32, wishbone data width (only 32 supported)
WB_ADDR_WIDTH, 32, wishbone address width
WB_SEL_WIDTH, WB_DATA_WIDTH/8, byte-select width (ignored; all accesses full-word)
FIFO_DEPTH, 4, receive FIFO entries, power of 2 (used only with UART_RX_FIFO_EN)

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-high
uart_rx_i  in  1  serial input, asynchronous to clk_i, idle high
wb_addr_i  in  WB_ADDR_WIDTH  byte address; bits [3:2] select the register
wb_data_i  in  WB_DATA_WIDTH  write data
wb_sel_i  in  WB_SEL_WIDTH  byte selects (ignored)
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_ack_o  out  1  acknowledge
wb_data_o  out  WB_DATA_WIDTH  read data
rx_irq_o  out  1  high while at least one byte is available

Behaviour:
- Reset values: wb_ack_o=0, wb_data_o=0, rx_irq_o=0, divider=1, FSM=IDLE, valid/overrun/frame_err=0, FIFO empty, synchroniser flops=1.
- Registers: 0 DIVIDER R/W 32b; 1 RXDATA RO, {24'b0,byte}, a read pops one entry; 2 STATUS, bit0 valid (RO), bit1 overrun, bit2 frame_err, bits 1-2 write-1-to-clear; 3 SANITY RO, 32'h5EC0B0B0. Writes to RO registers are acked and ignored.
- Bus: on cyc&stb with ack low, ack goes high on the next edge for exactly 1 cycle (ack <= access & ~ack). Read data is valid only while ack is high; otherwise wb_data_o=0. Pop, W1C and divider update take effect on the ack cycle. RXDATA read when empty returns 0 with no side effects.
- Input path: 2-flop synchroniser on uart_rx_i; the FSM sees the synchronised signal only.
- Bit period P = divider+2 cycles, matching the transmitter. Divider is latched into a working copy at start detection, so a divider write mid-frame affects the next frame only.
- FSM IDLE: on synchronised rx=0, latch divider, counter=0, go to START.
- FSM START: after (P>>1) cycles, sample. If 0, go to DATA; if 1 (glitch), go to IDLE with no flags set.
- FSM DATA: sample every P cycles; 8 bits, LSB first, shifted into the shift register; after bit 7 go to STOP.
- FSM STOP: after P cycles, sample. If 1, push the byte. If 0, set frame_err and discard the byte. In both cases go to IDLE; no wait for the line to return high, but IDLE requires a falling edge (previous sample 1) to start a new frame.
- Push while full: byte dropped, stored data unchanged, overrun set.
- Push and pop in the same cycle: both succeed; occupancy unchanged; no overrun, even when full.
- Flags are sticky until W1C. If a W1C and a new error arrive in the same cycle, set wins.
- rx_irq_o = valid, registered.
- Async reset mid-frame: FSM returns to IDLE immediately and the partial byte is lost.

Optional Feature:
UART_RX_FIFO_EN.
- Defined: received bytes go to a FIFO_DEPTH-entry FIFO. valid = not empty; overrun = push while FIFO_DEPTH entries held. STATUS bits [7:4] report occupancy (0..FIFO_DEPTH).
- Undefined: single holding register; STATUS bits [7:4] read 0.

Decomposition:
- Shared package uart_pkg: register index constants (DIVIDER/RXDATA/STATUS/SANITY), status bit positions, SANITY value, FSM state enum {IDLE,START,DATA,STOP}; the transmitter's constants migrate there too.
- One sub-module, uart_rx_fifo (sync FIFO with push/pop/full/empty/count), instantiated only under UART_RX_FIFO_EN.

Test Plan:
- Divider=2 (P=4); drive frame 0x55 -> STATUS=0x1, rx_irq_o=1, RXDATA=0x00000055, then STATUS=0x0, rx_irq_o=0.
- Stop bit driven 0 on byte 0x81 -> STATUS bit2=1, valid=0; write STATUS=0x4 -> STATUS=0x0.
- Frames 0xA5 then 0x3C with no read (no FIFO) -> RXDATA=0xA5, STATUS bit1=1. With FIFO: 5 frames 0x01..0x05 -> overrun=1, reads return 0x01..0x04.
- uart_rx_i low for 1 cycle at divider=10 -> FSM back to IDLE, STATUS=0x0, no byte.
- Assert rst_i during bit 4 of a frame, release, send 0x3C -> only 0x3C received, flags 0.
- Read SANITY -> 0x5EC0B0B0 with one-cycle ack; write DIVIDER=0x20 mid-frame -> current byte still correct at the old rate.
